mem_port_arbiter: RTL

- Shares the single-port system memory (mem_addr / mem_wr_data / mem_wr_ena / mem_rd_data) between two requesters: port 0 (CPU) and port 1 (loader/DMA/debug).
- Round-robin arbitration with a req/gnt/ack handshake; one access outstanding at a time.
- Sits between the requesters and the memory model; the memory side is identical to the CPU's existing memory interface.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester handshakes plus the single-port memory side.
// The arbiter connects through the slave modport; the environment
// (requesters and memory model) connects through the master modport.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);
    // Port 0 (CPU)
    logic              p0_req;
    logic              p0_we;
    logic [DATA_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;
    // Port 1 (loader / DMA / debug)
    logic              p1_req;
    logic              p1_we;
    logic [DATA_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;
    // Memory side
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ena;
    logic [DATA_W-1:0] mem_rd_data;
    // Status
    logic              busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_ack, p1_rdata,
        output mem_addr, mem_wr_data, mem_wr_ena,
        input  mem_rd_data,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_ack, p1_rdata,
        input  mem_addr, mem_wr_data, mem_wr_ena,
        output mem_rd_data,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// One access outstanding at a time: IDLE picks a winner and issues the
// access, WAIT counts RD_LATENCY edges, captures read data and acks.
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstb,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAT = 4'(RD_LATENCY);

    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: RD_LATENCY must be in 1..15");
    end

    // Registered state
    state_t            r_state;
    logic              r_owner;       // port of the access in flight
    logic              r_last_owner;  // port granted most recently
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wr_data;
    logic              r_mem_wr_ena;
    logic [1:0]        r_gnt;         // bit n = port n
    logic [1:0]        r_ack;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    // Next-state values
    state_t            w_state;
    logic              w_owner;
    logic              w_last_owner;
    logic [3:0]        w_cnt;
    logic [DATA_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wr_data;
    logic              w_mem_wr_ena;
    logic [1:0]        w_gnt;
    logic [1:0]        w_ack;
    logic [DATA_W-1:0] w_rdata0;
    logic [DATA_W-1:0] w_rdata1;
    logic              w_winner;

    // Next-state and output decode for the IDLE/WAIT controller
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state       = r_state;
        w_owner       = r_owner;
        w_last_owner  = r_last_owner;
        w_cnt         = r_cnt;
        w_mem_addr    = r_mem_addr;
        w_mem_wr_data = r_mem_wr_data;
        w_mem_wr_ena  = r_mem_wr_ena;
        w_gnt         = 2'b00;
        w_ack         = 2'b00;
        w_rdata0      = r_rdata0;
        w_rdata1      = r_rdata1;

        // Sole requester wins; on a tie the port that did not go last wins.
        w_winner = (bus.p0_req && bus.p1_req) ? ~r_last_owner : bus.p1_req;

        case (r_state)
            S_IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    w_mem_addr    = w_winner ? bus.p1_addr  : bus.p0_addr;
                    w_mem_wr_data = w_winner ? bus.p1_wdata : bus.p0_wdata;
                    w_mem_wr_ena  = w_winner ? bus.p1_we    : bus.p0_we;
                    w_owner       = w_winner;
                    w_last_owner  = w_winner;
                    w_gnt         = w_winner ? 2'b10 : 2'b01;
                    w_cnt         = LAT;
                    w_state       = S_WAIT;
                end
            end
            S_WAIT: begin
                // Write strobe lasts exactly the issue cycle.
                w_mem_wr_ena = 1'b0;
                if (r_cnt == 4'd1) begin
                    // Only the owner's read register is touched.
                    if (r_owner) w_rdata1 = bus.mem_rd_data;
                    else         w_rdata0 = bus.mem_rd_data;
                    w_ack   = r_owner ? 2'b10 : 2'b01;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_last_owner  <= 1'b1;
            r_cnt         <= 4'd0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_mem_wr_ena  <= 1'b0;
            r_gnt         <= 2'b00;
            r_ack         <= 2'b00;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_state       <= w_state;
            r_owner       <= w_owner;
            r_last_owner  <= w_last_owner;
            r_cnt         <= w_cnt;
            r_mem_addr    <= w_mem_addr;
            r_mem_wr_data <= w_mem_wr_data;
            r_mem_wr_ena  <= w_mem_wr_ena;
            r_gnt         <= w_gnt;
            r_ack         <= w_ack;
            r_rdata0      <= w_rdata0;
            r_rdata1      <= w_rdata1;
        end
    end

    assign bus.p0_gnt      = r_gnt[0];
    assign bus.p1_gnt      = r_gnt[1];
    assign bus.p0_ack      = r_ack[0];
    assign bus.p1_ack      = r_ack[1];
    assign bus.p0_rdata    = r_rdata0;
    assign bus.p1_rdata    = r_rdata1;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wr_data = r_mem_wr_data;
    assign bus.mem_wr_ena  = r_mem_wr_ena;
    assign bus.busy        = (r_state == S_WAIT);

endmodule
